// File: rtl/contador_modn_updown.sv
// Modulo-MOD up/down counter with clamped parallel load,
// cascade terminal count, zero flag and registered wrap pulse.
module contador_modn_updown #(
  parameter int MOD   = 6,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] data,
  input  logic             loadn,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             wrap
);

  generate
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
      $error("contador_modn_updown: MOD outside 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_max;
  logic             at_min;

  assign at_max = (count_q == MAX);
  assign at_min = (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (!loadn) begin
      // Out-of-range loads saturate so count stays in 0..MOD-1
      count_d = (data > MAX) ? MAX : data;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          count_d = MAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign zero  = at_min;
  assign tc    = en & loadn & ((up & at_max) | (~up & at_min));

endmodule
